// File: rtl/pfgen_stride_pkg.sv
// Shared types for the stride prefetch generator and its pfgtopfe_op channel.
// Its types are unaffected by PFGEN_THROTTLE_EN.
package pfgen_stride_pkg;

  localparam int PF_STRIDE_W = 12;
  localparam int PF_ADDR_W   = 39;

  typedef struct packed {
    logic [PF_ADDR_W-1:0]          laddr;
    logic signed [PF_STRIDE_W-1:0] stride;
    logic [3:0]                    n;
  } I_pfgtopfe_op_type;

  typedef struct packed {
    logic [15:0] nuseful;
    logic [15:0] nuseless;
  } PF_cache_stats_type;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pfgen_stride_table.sv
// Direct-mapped per-PC stride table: combinational lookup/train, write at the edge.
// Its behaviour is unaffected by PFGEN_THROTTLE_EN.
module pfgen_stride_table
  import pfgen_stride_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [IDX_W-1:0]             in_idx,
  input  logic [TAG_W-1:0]             in_tag,
  input  logic [PF_ADDR_W-1:0]         in_addr,
  output logic                         hit,
  output logic                         match,
  output logic [1:0]                   conf,
  output logic signed [PF_STRIDE_W-1:0] stride
);

  typedef struct packed {
    logic                   v;
    logic [TAG_W-1:0]       tag;
    logic [PF_ADDR_W-1:0]   last_addr;
    logic [PF_STRIDE_W-1:0] stride;
    logic [1:0]             conf;
  } entry_t;

  entry_t               tbl [ENTRIES];
  entry_t               ent;
  entry_t               ent_nxt;
  logic [PF_ADDR_W-1:0] delta;
  logic                 fits;

  always_comb begin
    ent   = tbl[in_idx];
    hit   = in_valid && ent.v && (ent.tag == in_tag);
    delta = in_addr - ent.last_addr;
    // Representable in signed 12 bits when bits 38..11 are a pure sign extension.
    fits  = (delta[PF_ADDR_W-1:PF_STRIDE_W-1] == '0) ||
            (delta[PF_ADDR_W-1:PF_STRIDE_W-1] == '1);
    match = hit && fits && (delta[PF_STRIDE_W-1:0] == ent.stride) && (delta != '0);

    ent_nxt           = ent;
    ent_nxt.last_addr = in_addr;
    if (!hit) begin
      ent_nxt.v      = 1'b1;
      ent_nxt.tag    = in_tag;
      ent_nxt.stride = '0;
      ent_nxt.conf   = 2'd0;
    end else if (match) begin
      if (ent.conf != 2'd3) ent_nxt.conf = ent.conf + 2'd1;
    end else if (ent.conf != 2'd0) begin
      ent_nxt.conf = ent.conf - 2'd1;
    end else begin
      ent_nxt.stride = fits ? delta[PF_STRIDE_W-1:0] : '0;
    end

    conf   = ent_nxt.conf;
    stride = ent.stride;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
    end else if (in_valid) begin
      tbl[in_idx] <= ent_nxt;
    end
  end

endmodule

// File: rtl/pfgen_stride.sv
// Stride prefetch generator: input stage, table training, 1-deep op register, counters.
// Define PFGEN_THROTTLE_EN to throttle degree/suppress candidates from pf_dcstats.
module pfgen_stride
  import pfgen_stride_pkg::*;
#(
  parameter int ENTRIES     = 16,
  parameter int TAG_W       = 8,
  parameter int CONF_THRESH = 2,
  parameter int DEGREE      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_valid,
  input  logic [38:0]        ld_pc,
  input  logic [38:0]        ld_laddr,
  output logic               pfgtopfe_op_valid,
  input  logic               pfgtopfe_op_retry,
  output I_pfgtopfe_op_type  pfgtopfe_op,
  input  PF_cache_stats_type pf_dcstats,
  output logic [15:0]        pf_issued,
  output logic [15:0]        pf_dropped
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic                          s1_valid;
  logic [IDX_W-1:0]              s1_idx;
  logic [TAG_W-1:0]              s1_tag;
  logic [PF_ADDR_W-1:0]          s1_addr;
  logic                          tbl_hit;
  logic                          tbl_match;
  logic [1:0]                    tbl_conf;
  logic signed [PF_STRIDE_W-1:0] tbl_stride;
  logic [3:0]                    eff_degree;
  logic                          suppress;
  logic                          cand;
  logic                          xfer;
  logic                          load_op;
  logic                          drop;
  I_pfgtopfe_op_type             cand_op;
  logic                          unused_pc;

  assign unused_pc = ^{ld_pc[38:IDX_W+2+TAG_W], ld_pc[1:0]};

  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= ld_valid;
  end

  always_ff @(posedge clk) begin
    s1_idx  <= ld_pc[IDX_W+1:2];
    s1_tag  <= ld_pc[IDX_W+2 +: TAG_W];
    s1_addr <= ld_laddr;
  end

  pfgen_stride_table #(
    .ENTRIES (ENTRIES),
    .TAG_W   (TAG_W)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .in_valid (s1_valid),
    .in_idx   (s1_idx),
    .in_tag   (s1_tag),
    .in_addr  (s1_addr),
    .hit      (tbl_hit),
    .match    (tbl_match),
    .conf     (tbl_conf),
    .stride   (tbl_stride)
  );

`ifdef PFGEN_THROTTLE_EN
  PF_cache_stats_type stats_q;

  always_ff @(posedge clk) begin
    if (reset) stats_q <= '0;
    else       stats_q <= pf_dcstats;
  end

  always_comb begin
    eff_degree = (stats_q.nuseless > stats_q.nuseful) ? 4'd1 : 4'(DEGREE);
    suppress   = ({1'b0, stats_q.nuseless} > {stats_q.nuseful, 1'b0}) &&
                 (stats_q.nuseless >= 16'd64);
  end
`else
  logic unused_stats;
  assign unused_stats = ^pf_dcstats;
  assign eff_degree   = 4'(DEGREE);
  assign suppress     = 1'b0;
`endif

  always_comb begin
    cand           = tbl_hit && tbl_match && (tbl_conf >= 2'(CONF_THRESH)) && !suppress;
    cand_op.laddr  = s1_addr + {{(PF_ADDR_W-PF_STRIDE_W){tbl_stride[PF_STRIDE_W-1]}}, tbl_stride};
    cand_op.stride = tbl_stride;
    cand_op.n      = eff_degree;
    xfer           = pfgtopfe_op_valid && !pfgtopfe_op_retry;
    // A transfer and a new load can share a cycle; only a held op blocks.
    load_op        = cand && (!pfgtopfe_op_valid || !pfgtopfe_op_retry);
    drop           = cand && pfgtopfe_op_valid && pfgtopfe_op_retry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pfgtopfe_op_valid <= 1'b0;
      pfgtopfe_op       <= '0;
      pf_issued         <= '0;
      pf_dropped        <= '0;
    end else begin
      if (load_op) begin
        pfgtopfe_op_valid <= 1'b1;
        pfgtopfe_op       <= cand_op;
      end else if (xfer) begin
        pfgtopfe_op_valid <= 1'b0;
      end
      if (xfer) pf_issued  <= sat_inc16(pf_issued);
      if (drop) pf_dropped <= sat_inc16(pf_dropped);
    end
  end

endmodule

// File: tb/tb_pfgen_stride.sv
// Directed self-checking bench for pfgen_stride (throttle test under PFGEN_THROTTLE_EN).
module tb_pfgen_stride;
  import pfgen_stride_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               ld_valid;
  logic [38:0]        ld_pc;
  logic [38:0]        ld_laddr;
  logic               pfgtopfe_op_valid;
  logic               pfgtopfe_op_retry;
  I_pfgtopfe_op_type  pfgtopfe_op;
  PF_cache_stats_type pf_dcstats;
  logic [15:0]        pf_issued;
  logic [15:0]        pf_dropped;

  int vec_count   = 0;
  int miscompares = 0;

  pfgen_stride dut (
    .clk               (clk),
    .reset             (reset),
    .ld_valid          (ld_valid),
    .ld_pc             (ld_pc),
    .ld_laddr          (ld_laddr),
    .pfgtopfe_op_valid (pfgtopfe_op_valid),
    .pfgtopfe_op_retry (pfgtopfe_op_retry),
    .pfgtopfe_op       (pfgtopfe_op),
    .pf_dcstats        (pf_dcstats),
    .pf_issued         (pf_issued),
    .pf_dropped        (pf_dropped)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [38:0] pc, input logic [38:0] addr);
    ld_valid = 1'b1;
    ld_pc    = pc;
    ld_laddr = addr;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vec_count++;
    if (pfgtopfe_op_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b expected 0", pfgtopfe_op_valid);
    end
    vec_count++;
    if (pfgtopfe_op !== '0) begin
      miscompares++; $display("FAIL reset_op: got %h expected 0", pfgtopfe_op);
    end
    vec_count++;
    if (pf_issued !== 16'd0 || pf_dropped !== 16'd0) begin
      miscompares++; $display("FAIL reset_counters: got %h/%h expected 0/0", pf_issued, pf_dropped);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_load(39'h1000, 39'h100);
    do_load(39'h1000, 39'h140);
    do_load(39'h1000, 39'h180);
    do_load(39'h1000, 39'h1C0);
    vec_count++;
    if (pfgtopfe_op_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_latency: got valid %b expected 0 one cycle after load", pfgtopfe_op_valid);
    end
    step();
    vec_count++;
    if (pfgtopfe_op_valid !== 1'b1 || pfgtopfe_op.laddr !== 39'h200) begin
      miscompares++; $display("FAIL basic_op: got valid %b laddr %h expected 1 200", pfgtopfe_op_valid, pfgtopfe_op.laddr);
    end
    vec_count++;
    if (pfgtopfe_op.stride !== 12'sh040 || pfgtopfe_op.n !== 4'd4) begin
      miscompares++; $display("FAIL basic_fields: got stride %h n %0d expected 040 4", pfgtopfe_op.stride, pfgtopfe_op.n);
    end
    do_load(39'h1000, 39'h200);
    vec_count++;
    if (pfgtopfe_op_valid !== 1'b0 || pf_issued !== 16'd1) begin
      miscompares++; $display("FAIL basic_xfer: got valid %b issued %0d expected 0 1", pfgtopfe_op_valid, pf_issued);
    end
    step();
    vec_count++;
    if (pfgtopfe_op_valid !== 1'b1 || pfgtopfe_op.laddr !== 39'h240) begin
      miscompares++; $display("FAIL basic_next: got valid %b laddr %h expected 1 240", pfgtopfe_op_valid, pfgtopfe_op.laddr);
    end
    step();
    vec_count++;
    if (pf_issued !== 16'd2 || pf_dropped !== 16'd0 || pfgtopfe_op_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_counts: got issued %0d dropped %0d valid %b expected 2 0 0", pf_issued, pf_dropped, pfgtopfe_op_valid);
    end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    pfgtopfe_op_retry = 1'b1;
    do_load(39'h1000, 39'h100);
    do_load(39'h1000, 39'h140);
    do_load(39'h1000, 39'h180);
    do_load(39'h1000, 39'h1C0);
    step();
    vec_count++;
    if (pfgtopfe_op_valid !== 1'b1 || pfgtopfe_op.laddr !== 39'h200) begin
      miscompares++; $display("FAIL bp_op: got valid %b laddr %h expected 1 200", pfgtopfe_op_valid, pfgtopfe_op.laddr);
    end
    do_load(39'h1000, 39'h200);
    step();
    vec_count++;
    if (pfgtopfe_op_valid !== 1'b1 || pfgtopfe_op.laddr !== 39'h200) begin
      miscompares++; $display("FAIL bp_hold: got valid %b laddr %h expected 1 200", pfgtopfe_op_valid, pfgtopfe_op.laddr);
    end
    vec_count++;
    if (pf_dropped !== 16'd1 || pf_issued !== 16'd0) begin
      miscompares++; $display("FAIL bp_drop: got dropped %0d issued %0d expected 1 0", pf_dropped, pf_issued);
    end
    pfgtopfe_op_retry = 1'b0;
    step();
    vec_count++;
    if (pf_issued !== 16'd1 || pfgtopfe_op_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_release: got issued %0d valid %b expected 1 0", pf_issued, pfgtopfe_op_valid);
    end
  endtask

  task automatic test_alternating();
    logic [38:0] addrs [6];
    addrs = '{39'h100, 39'h140, 39'h100, 39'h140, 39'h100, 39'h140};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      do_load(39'h2000, addrs[i]);
      step();
      vec_count++;
      if (pfgtopfe_op_valid !== 1'b0) begin
        miscompares++; $display("FAIL alt_no_op[%0d]: got valid %b expected 0", i, pfgtopfe_op_valid);
      end
    end
    // Last delta was +0x40 with conf 0, so the stride retrained to +0x40.
    do_load(39'h2000, 39'h180);
    do_load(39'h2000, 39'h1C0);
    step();
    vec_count++;
    if (pfgtopfe_op_valid !== 1'b1 || pfgtopfe_op.laddr !== 39'h200) begin
      miscompares++; $display("FAIL alt_retrain: got valid %b laddr %h expected 1 200", pfgtopfe_op_valid, pfgtopfe_op.laddr);
    end
    step();
  endtask

  task automatic test_big_delta_wrap();
    logic [38:0] big [4];
    big = '{39'h0, 39'h1000, 39'h2000, 39'h3000};
    for (int i = 0; i < 4; i++) begin
      do_load(39'h3000, big[i]);
      step();
      vec_count++;
      if (pfgtopfe_op_valid !== 1'b0) begin
        miscompares++; $display("FAIL big_no_op[%0d]: got valid %b expected 0", i, pfgtopfe_op_valid);
      end
    end
    do_load(39'h4000, 39'h7F_FFFF_FF00);
    do_load(39'h4000, 39'h7F_FFFF_FF40);
    do_load(39'h4000, 39'h7F_FFFF_FF80);
    do_load(39'h4000, 39'h7F_FFFF_FFC0);
    step();
    vec_count++;
    if (pfgtopfe_op_valid !== 1'b1 || pfgtopfe_op.laddr !== 39'h0 || pfgtopfe_op.stride !== 12'sh040) begin
      miscompares++; $display("FAIL wrap_op: got valid %b laddr %h stride %h expected 1 0 040",
                              pfgtopfe_op_valid, pfgtopfe_op.laddr, pfgtopfe_op.stride);
    end
    step();
  endtask

  task automatic test_alias();
    logic [38:0] seq_pc   [9];
    logic [38:0] seq_addr [9];
    logic        seen;
    seq_pc   = '{39'h1000, 39'h1040, 39'h1000, 39'h1040, 39'h1000, 39'h1040, 39'h1000, 39'h1040, 39'h1000};
    seq_addr = '{39'h100, 39'h500, 39'h140, 39'h540, 39'h180, 39'h580, 39'h1C0, 39'h5C0, 39'h200};
    seen = 1'b0;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      do_load(seq_pc[i], seq_addr[i]);
      if (pfgtopfe_op_valid) seen = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (pfgtopfe_op_valid) seen = 1'b1;
    end
    vec_count++;
    if (seen !== 1'b0 || pf_issued !== 16'd0) begin
      miscompares++; $display("FAIL alias_no_op: got seen %b issued %0d expected 0 0", seen, pf_issued);
    end
  endtask

  task automatic test_reset_mid();
    pfgtopfe_op_retry = 1'b1;
    do_load(39'h1000, 39'h100);
    do_load(39'h1000, 39'h140);
    do_load(39'h1000, 39'h180);
    do_load(39'h1000, 39'h1C0);
    step();
    do_load(39'h1000, 39'h200);
    step();
    vec_count++;
    if (pfgtopfe_op_valid !== 1'b1 || pf_dropped !== 16'd1) begin
      miscompares++; $display("FAIL rmid_setup: got valid %b dropped %0d expected 1 1", pfgtopfe_op_valid, pf_dropped);
    end
    reset = 1'b1;
    step();
    vec_count++;
    if (pfgtopfe_op_valid !== 1'b0 || pfgtopfe_op !== '0) begin
      miscompares++; $display("FAIL rmid_valid: got valid %b op %h expected 0 0", pfgtopfe_op_valid, pfgtopfe_op);
    end
    vec_count++;
    if (pf_issued !== 16'd0 || pf_dropped !== 16'd0) begin
      miscompares++; $display("FAIL rmid_counters: got %0d/%0d expected 0/0", pf_issued, pf_dropped);
    end
    reset = 1'b0;
    pfgtopfe_op_retry = 1'b0;
    step();
    vec_count++;
    if (pfgtopfe_op_valid !== 1'b0 || pf_issued !== 16'd0) begin
      miscompares++; $display("FAIL rmid_after: got valid %b issued %0d expected 0 0", pfgtopfe_op_valid, pf_issued);
    end
  endtask

`ifdef PFGEN_THROTTLE_EN
  task automatic test_throttle();
    logic [38:0] addrs [5];
    addrs = '{39'h100, 39'h140, 39'h180, 39'h1C0, 39'h200};
    apply_reset();
    pf_dcstats.nuseful  = 16'd10;
    pf_dcstats.nuseless = 16'd70;
    step();
    for (int i = 0; i < 5; i++) begin
      do_load(39'h5000, addrs[i]);
      step();
      vec_count++;
      if (pfgtopfe_op_valid !== 1'b0 || pf_dropped !== 16'd0) begin
        miscompares++; $display("FAIL thr_suppress[%0d]: got valid %b dropped %0d expected 0 0", i, pfgtopfe_op_valid, pf_dropped);
      end
    end
    pf_dcstats.nuseless = 16'd15;
    step();
    do_load(39'h5000, 39'h240);
    step();
    vec_count++;
    if (pfgtopfe_op_valid !== 1'b1 || pfgtopfe_op.laddr !== 39'h280 || pfgtopfe_op.n !== 4'd1) begin
      miscompares++; $display("FAIL thr_degree: got valid %b laddr %h n %0d expected 1 280 1",
                              pfgtopfe_op_valid, pfgtopfe_op.laddr, pfgtopfe_op.n);
    end
    step();
    pf_dcstats = '0;
  endtask
`endif

  initial begin
    reset             = 1'b1;
    ld_valid          = 1'b0;
    ld_pc             = '0;
    ld_laddr          = '0;
    pfgtopfe_op_retry = 1'b0;
    pf_dcstats        = '0;
    test_reset();
    test_basic();
    test_back_pressure();
    test_alternating();
    test_big_delta_wrap();
    test_alias();
    test_reset_mid();
`ifdef PFGEN_THROTTLE_EN
    test_throttle();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
